// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: base opcodes, immediate-format select encoding,
// and the decode-stage buffer states.
package riscv_pkg;

  localparam int INST_W    = 32;
  localparam int INST_HI_W = 25;  // inst[31:7], everything above the opcode

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/decode_stage_dec.sv
// Combinational opcode decoder: selects the immediate format and flags
// opcodes outside the supported base set.
module decode_stage_dec
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [2:0] imm_sel_o,
  output logic       illegal_o
);

  imm_sel_e sel;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement can infer a latch.
  always_comb begin
    sel       = IMM_NONE;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: sel = IMM_I;
      OPC_STORE:                                  sel = IMM_S;
      OPC_BRANCH:                                 sel = IMM_B;
      OPC_LUI, OPC_AUIPC:                         sel = IMM_U;
      OPC_JAL:                                    sel = IMM_J;
      OPC_OP:                                     sel = IMM_NONE;
      default:                                    illegal_o = 1'b1;
    endcase
  end

  assign imm_sel_o = sel;

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes on the input path and holds results in a two-entry
// skid buffer (main drives the outputs, skid absorbs one extra beat).
module decode_stage
  import riscv_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [24:0]      inst_in,
  output logic [2:0]       imm_sel,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [PC_W-1:0]  out_pc,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [INST_HI_W-1:0] inst_hi;
    logic [2:0]           imm_sel;
    logic                 illegal;
    logic [PC_W-1:0]      pc;
  } entry_t;

  buf_state_e       state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           in_entry;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [2:0]       dec_sel;
  logic             dec_illegal;
  logic             in_fire;
  logic             out_fire;

  decode_stage_dec u_dec (
    .opcode_i  (in_inst[6:0]),
    .imm_sel_o (dec_sel),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    in_entry.inst_hi = in_inst[31:7];
    in_entry.imm_sel = dec_sel;
    in_entry.illegal = dec_illegal;
    in_entry.pc      = in_pc;
  end

  // Handshake flags come straight from the state register, so in_ready never
  // depends combinationally on out_ready.
  assign in_ready  = (state_q != BUF_FULL);
  assign out_valid = (state_q != BUF_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (in_fire) begin
            state_d = BUF_ONE;
            main_d  = in_entry;
          end
        end
        BUF_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_entry;
          end else if (in_fire) begin
            state_d = BUF_FULL;
            skid_d  = in_entry;
          end else if (out_fire) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (out_fire) begin
            state_d = BUF_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  // Saturates instead of wrapping; flush deliberately leaves it alone.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // NOTE: state uses non-blocking assignments; the data registers are reset
  // as well because every output field must read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  // Register indices are slices of inst[31:7], offset by the 7 opcode bits.
  assign inst_in   = main_q.inst_hi;
  assign imm_sel   = main_q.imm_sel;
  assign illegal   = main_q.illegal;
  assign out_pc    = main_q.pc;
  assign rs1       = main_q.inst_hi[12:8];
  assign rs2       = main_q.inst_hi[17:13];
  assign rd        = main_q.inst_hi[4:0];
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_decode_stage;

  localparam int PC_W    = 32;
  localparam int CNT_W   = 4;
  localparam int STL_MAX = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_inst = '0;
  logic [PC_W-1:0]  in_pc = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [24:0]      inst_in;
  logic [2:0]       imm_sel;
  logic [4:0]       rs1, rs2, rd;
  logic [PC_W-1:0]  out_pc;
  logic             illegal;
  logic [CNT_W-1:0] stall_cnt;

  decode_stage #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inst_in   (inst_in),
    .imm_sel   (imm_sel),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .out_pc    (out_pc),
    .illegal   (illegal),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } item_t;

  item_t mq[$];
  int    stall_m = 0;
  int    total = 0;
  int    bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode written from the opcode table: returns {illegal, imm_sel}.
  function automatic logic [3:0] ref_dec(input logic [6:0] op);
    if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73) return 4'h1;
    if (op == 7'h23) return 4'h2;
    if (op == 7'h63) return 4'h3;
    if (op == 7'h37 || op == 7'h17) return 4'h4;
    if (op == 7'h6F) return 4'h5;
    if (op == 7'h33) return 4'h0;
    return 4'h8;
  endfunction

  task automatic compare_all();
    item_t       e;
    logic [3:0]  d;
    logic [31:0] w;
    check("out_valid", out_valid, mq.size() > 0);
    check("in_ready", in_ready, mq.size() < 2);
    check("stall_cnt", stall_cnt, stall_m);
    if (mq.size() > 0) begin
      e = mq[0];
      w = e.inst;
      d = ref_dec(w[6:0]);
      check("inst_in", inst_in, w[31:7]);
      check("imm_sel", imm_sel, d[2:0]);
      check("illegal", illegal, d[3]);
      check("rs1", rs1, w[19:15]);
      check("rs2", rs2, w[24:20]);
      check("rd", rd, w[11:7]);
      check("out_pc", out_pc, e.pc);
    end
  endtask

  // One clock: the model applies the inputs driven before the edge, then
  // outputs are compared at the following falling edge.
  task automatic cycle();
    bit    in_fire, out_fire;
    item_t it;
    in_fire  = in_valid && (mq.size() < 2);
    out_fire = (mq.size() > 0) && out_ready;
    if (mq.size() > 0 && !out_ready && stall_m < STL_MAX) stall_m++;
    it.inst = in_inst;
    it.pc   = in_pc;
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (out_fire) void'(mq.pop_front());
      if (in_fire) mq.push_back(it);
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [PC_W-1:0] pc);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [11];
    logic [31:0] w;
    ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 10)];
    if ($urandom_range(0, 7) == 0) w[6:0] = 7'($urandom);
    return w;
  endfunction

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    compare_all();
    check("rst_inst_in", inst_in, 0);
    check("rst_imm_sel", imm_sel, 0);
    check("rst_rd", rd, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_illegal", illegal, 0);
    rst_n = 1'b1;

    // addi x1,x0,100 with one-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 32'h06400093, 32'h100);
    cycle();
    drive(1'b0, '0, '0);
    check("addi_valid", out_valid, 1);
    check("addi_imm", imm_sel, 1);
    check("addi_rd", rd, 1);
    check("addi_rs1", rs1, 0);
    check("addi_ill", illegal, 0);
    check("addi_inst", inst_in, 25'h0C8001);
    cycle();

    // sw then beq under backpressure, delivered in order
    out_ready = 1'b0;
    drive(1'b1, 32'h00112223, 32'h200);
    cycle();
    drive(1'b1, 32'h00208463, 32'h204);
    cycle();
    drive(1'b0, '0, '0);
    check("full_in_ready", in_ready, 0);
    out_ready = 1'b1;
    check("order_first", imm_sel, 2);
    cycle();
    check("order_second", imm_sel, 3);
    check("order_pc", out_pc, 32'h204);
    cycle();
    check("drained", out_valid, 0);

    // Flush while FULL together with an input
    out_ready = 1'b0;
    drive(1'b1, 32'h00000013, 32'h300);
    cycle();
    drive(1'b1, 32'h00000033, 32'h304);
    cycle();
    flush = 1'b1;
    drive(1'b1, 32'h0000006F, 32'h308);
    cycle();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 1);
    out_ready = 1'b1;
    drive(1'b1, 32'h00500113, 32'h400);
    cycle();
    drive(1'b0, '0, '0);
    check("post_flush_pc", out_pc, 32'h400);
    cycle();

    // jal, lui, unknown opcode back to back
    drive(1'b1, 32'h0080006F, 32'h500);
    cycle();
    check("jal_imm", imm_sel, 5);
    check("jal_ill", illegal, 0);
    drive(1'b1, 32'h000010B7, 32'h504);
    cycle();
    check("lui_imm", imm_sel, 4);
    check("lui_ill", illegal, 0);
    drive(1'b1, 32'h0000007F, 32'h508);
    cycle();
    check("bad_imm", imm_sel, 0);
    check("bad_ill", illegal, 1);
    drive(1'b0, '0, '0);
    cycle();

    // Stall counter saturation, then async reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 32'h00000093, 32'h600);
    cycle();
    drive(1'b0, '0, '0);
    repeat (20) cycle();
    check("stall_sat", stall_cnt, 15);
    drive(1'b1, 32'h00000113, 32'h604);
    cycle();
    drive(1'b0, '0, '0);
    check("pre_rst_full", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_stall", stall_cnt, 0);
    check("arst_ready", in_ready, 1);
    mq.delete();
    stall_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      drive($urandom_range(0, 2) != 0, rand_inst(), $urandom);
      cycle();
    end
    flush = 1'b0;
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
